// File: rtl/order_cmd_dispatcher_if.sv
// Bundle of message, engine and response signals for the order command dispatcher.
// The dispatcher uses the slave modport; the parser/engines/reporter side uses master.
interface order_cmd_dispatcher_if #(
    parameter int ID_W  = 16,
    parameter int QTY_W = 16,
    parameter int PX_W  = 16
);
    logic             msg_valid;
    logic             msg_ready;
    logic [1:0]       msg_type;
    logic             msg_side;
    logic [ID_W-1:0]  msg_id;
    logic [QTY_W-1:0] msg_size;
    logic [PX_W-1:0]  msg_limit;

    logic             add_start;
    logic             del_start;
    logic             vol_start;
    logic             eng_side;
    logic [ID_W-1:0]  eng_id;
    logic [QTY_W-1:0] eng_size;
    logic [PX_W-1:0]  eng_limit;

    logic             add_done;
    logic             add_success;
    logic             del_done;
    logic             del_success;
    logic             vol_done;
    logic [QTY_W-1:0] vol_volume;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_type;
    logic             rsp_success;
    logic             rsp_err;
    logic [QTY_W-1:0] rsp_volume;

    modport slave (
        input  msg_valid, msg_type, msg_side, msg_id, msg_size, msg_limit,
        output msg_ready,
        output add_start, del_start, vol_start,
        output eng_side, eng_id, eng_size, eng_limit,
        input  add_done, add_success, del_done, del_success, vol_done, vol_volume,
        output rsp_valid, rsp_type, rsp_success, rsp_err, rsp_volume,
        input  rsp_ready
    );

    modport master (
        output msg_valid, msg_type, msg_side, msg_id, msg_size, msg_limit,
        input  msg_ready,
        input  add_start, del_start, vol_start,
        input  eng_side, eng_id, eng_size, eng_limit,
        output add_done, add_success, del_done, del_success, vol_done, vol_volume,
        input  rsp_valid, rsp_type, rsp_success, rsp_err, rsp_volume,
        output rsp_ready
    );
endinterface

// File: rtl/order_cmd_dispatcher.sv
// One-in-flight dispatcher from parsed order messages to the add/delete/volume book engines.
// Optional WAIT watchdog enabled by defining DISPATCH_TIMEOUT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | msg_ready high, waiting for a parsed message
// ST_ISSUE | start pulse on the selected engine (none for invalid type)
// ST_WAIT  | waiting for the selected engine's done (optionally bounded)
// ST_RESP  | response presented, held until rsp_ready
module order_cmd_dispatcher #(
    parameter int ID_W           = 16,
    parameter int QTY_W          = 16,
    parameter int PX_W           = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    order_cmd_dispatcher_if.slave     bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] TYPE_ADD = 2'b00;
    localparam logic [1:0] TYPE_DEL = 2'b01;
    localparam logic [1:0] TYPE_VOL = 2'b10;
    localparam logic [1:0] TYPE_INV = 2'b11;

    logic [1:0]       state;
    logic [1:0]       cmd_type;
    logic             eng_side_q;
    logic [ID_W-1:0]  eng_id_q;
    logic [QTY_W-1:0] eng_size_q;
    logic [PX_W-1:0]  eng_limit_q;
    logic             add_start_q;
    logic             del_start_q;
    logic             vol_start_q;
    logic             rsp_success_q;
    logic             rsp_err_q;
    logic [QTY_W-1:0] rsp_volume_q;

    logic             done_sel;
    logic             success_sel;
    logic             timeout_hit;

    // Only the engine matching the latched command is listened to.
    always_comb begin
        done_sel    = 1'b0;
        success_sel = 1'b0;
        case (cmd_type)
            TYPE_ADD: begin
                done_sel    = bus.add_done;
                success_sel = bus.add_success;
            end
            TYPE_DEL: begin
                done_sel    = bus.del_done;
                success_sel = bus.del_success;
            end
            TYPE_VOL: begin
                done_sel    = bus.vol_done;
                success_sel = 1'b1;
            end
            default: begin
                done_sel    = 1'b0;
                success_sel = 1'b0;
            end
        endcase
    end

`ifdef DISPATCH_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state != ST_WAIT) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_LAST) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Expiry on the last WAIT cycle; a done in that same cycle takes priority in the FSM.
    assign timeout_hit = (state == ST_WAIT) && (wait_cnt == CNT_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cmd_type      <= 2'b00;
            eng_side_q    <= 1'b0;
            eng_id_q      <= '0;
            eng_size_q    <= '0;
            eng_limit_q   <= '0;
            add_start_q   <= 1'b0;
            del_start_q   <= 1'b0;
            vol_start_q   <= 1'b0;
            rsp_success_q <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_volume_q  <= '0;
        end else begin
            add_start_q <= 1'b0;
            del_start_q <= 1'b0;
            vol_start_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.msg_valid) begin
                        state         <= ST_ISSUE;
                        cmd_type      <= bus.msg_type;
                        eng_side_q    <= bus.msg_side;
                        eng_id_q      <= bus.msg_id;
                        eng_size_q    <= bus.msg_size;
                        eng_limit_q   <= bus.msg_limit;
                        rsp_success_q <= 1'b0;
                        rsp_err_q     <= 1'b0;
                        rsp_volume_q  <= '0;
                        add_start_q   <= (bus.msg_type == TYPE_ADD);
                        del_start_q   <= (bus.msg_type == TYPE_DEL);
                        vol_start_q   <= (bus.msg_type == TYPE_VOL);
                    end
                end
                ST_ISSUE: begin
                    if (cmd_type == TYPE_INV) begin
                        state     <= ST_RESP;
                        rsp_err_q <= 1'b1;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (done_sel) begin
                        state         <= ST_RESP;
                        rsp_success_q <= success_sel;
                        rsp_volume_q  <= (cmd_type == TYPE_VOL) ? bus.vol_volume : '0;
                    end else if (timeout_hit) begin
                        state     <= ST_RESP;
                        rsp_err_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.msg_ready   = (state == ST_IDLE);
    assign bus.add_start   = add_start_q;
    assign bus.del_start   = del_start_q;
    assign bus.vol_start   = vol_start_q;
    assign bus.eng_side    = eng_side_q;
    assign bus.eng_id      = eng_id_q;
    assign bus.eng_size    = eng_size_q;
    assign bus.eng_limit   = eng_limit_q;
    assign bus.rsp_valid   = (state == ST_RESP);
    assign bus.rsp_type    = cmd_type;
    assign bus.rsp_success = rsp_success_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_volume  = rsp_volume_q;

endmodule
